// File: rtl/cle_sram_arbiter.sv
// cle_sram_arbiter: shares the single-port label SRAM between the first-pass
// label writer (requester 0) and the second-pass relabeller (requester 1).
// Round-robin arbitration with optional ownership lock and forced release.
// Optional feature macro: CLE_ARB_FIXED_PRIO_EN (requester 0 wins ties).
module cle_sram_arbiter #(
    parameter int unsigned AW       = 10,
    parameter int unsigned DW       = 8,
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] sram_a,
    output logic [DW-1:0] sram_d,
    output logic          sram_wen,
    input  logic [DW-1:0] sram_q
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] LOCK_LIM = CW'(LOCK_MAX);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_0    = 2'd1,
        OWN_1    = 2'd2
    } owner_t;

    owner_t        owner, owner_nx, eff_owner;
    logic [CW-1:0] lock_cnt, lock_cnt_nx, cnt_base;
    logic          last, last_nx;
    logic          pend0, pend1, pend0_nx, pend1_nx;
    logic          rvalid0_nx, rvalid1_nx;
    logic [AW-1:0] sram_a_nx;
    logic [DW-1:0] sram_d_nx;
    logic          sram_wen_nx;
    logic          g0, g1, tie1;
`ifdef CLE_ARB_FIXED_PRIO_EN
    logic          force1, force1_nx;
`endif

    // Arbitration: an owner whose request dropped is released this same cycle
    always_comb begin
        eff_owner = owner;
        g0        = 1'b0;
        g1        = 1'b0;
        if ((owner == OWN_0 && !req0) || (owner == OWN_1 && !req1)) begin
            eff_owner = OWN_NONE;
        end
`ifdef CLE_ARB_FIXED_PRIO_EN
        tie1 = force1;
`else
        tie1 = ~last;
`endif
        case (eff_owner)
            OWN_0:   g0 = 1'b1;
            OWN_1:   g1 = 1'b1;
            default: begin
                if (req0 && req1) begin
                    g0 = ~tie1;
                    g1 = tie1;
                end else begin
                    g0 = req0;
                    g1 = req1;
                end
            end
        endcase
        g0 = g0 & reset;
        g1 = g1 & reset;
    end

    assign gnt0  = g0;
    assign gnt1  = g1;
    assign rdata = sram_q;

    // Next-state: lock bookkeeping, SRAM port capture and read-return pipeline
    always_comb begin
        owner_nx    = eff_owner;
        cnt_base    = (eff_owner == OWN_NONE) ? '0 : lock_cnt;
        lock_cnt_nx = cnt_base;
        last_nx     = last;
        sram_a_nx   = sram_a;
        sram_d_nx   = sram_d;
        sram_wen_nx = 1'b1;
        pend0_nx    = g0 & ~we0;
        pend1_nx    = g1 & ~we1;
        rvalid0_nx  = pend0;
        rvalid1_nx  = pend1;
`ifdef CLE_ARB_FIXED_PRIO_EN
        force1_nx   = force1;
`endif
        if (g0 || g1) begin
            last_nx     = g1;
            sram_a_nx   = g1 ? addr1 : addr0;
            sram_d_nx   = g1 ? wdata1 : wdata0;
            sram_wen_nx = g1 ? ~we1 : ~we0;
`ifdef CLE_ARB_FIXED_PRIO_EN
            force1_nx   = 1'b0;
`endif
            if ((g0 && lock0) || (g1 && lock1)) begin
                if (cnt_base + CW'(1) >= LOCK_LIM) begin
                    // forced release so the other side cannot starve
                    owner_nx    = OWN_NONE;
                    lock_cnt_nx = '0;
`ifdef CLE_ARB_FIXED_PRIO_EN
                    force1_nx   = g0;
`endif
                end else begin
                    owner_nx    = g1 ? OWN_1 : OWN_0;
                    lock_cnt_nx = cnt_base + CW'(1);
                end
            end else begin
                owner_nx    = OWN_NONE;
                lock_cnt_nx = '0;
            end
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            owner    <= OWN_NONE;
            lock_cnt <= '0;
            last     <= 1'b1;
            sram_a   <= '0;
            sram_d   <= '0;
            sram_wen <= 1'b1;
            pend0    <= 1'b0;
            pend1    <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
`ifdef CLE_ARB_FIXED_PRIO_EN
            force1   <= 1'b0;
`endif
        end else begin
            owner    <= owner_nx;
            lock_cnt <= lock_cnt_nx;
            last     <= last_nx;
            sram_a   <= sram_a_nx;
            sram_d   <= sram_d_nx;
            sram_wen <= sram_wen_nx;
            pend0    <= pend0_nx;
            pend1    <= pend1_nx;
            rvalid0  <= rvalid0_nx;
            rvalid1  <= rvalid1_nx;
`ifdef CLE_ARB_FIXED_PRIO_EN
            force1   <= force1_nx;
`endif
        end
    end

endmodule

// File: tb/tb_cle_sram_arbiter.sv
// Directed bench for cle_sram_arbiter with a behavioural 1024x8 SRAM model.
module tb_cle_sram_arbiter;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 8;

    logic          clk;
    logic          reset;
    logic          req0, req1, we0, we1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_d;
    logic          sram_wen;
    logic [DW-1:0] sram_q;
    logic [DW-1:0] mem [1024];

    int checks = 0;
    int passes = 0;

    cle_sram_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .sram_a(sram_a), .sram_d(sram_d),
        .sram_wen(sram_wen), .sram_q(sram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port SRAM: mem[i] preloaded with i*3+1
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 3 + 1);
    end
    always @(posedge clk) begin
        if (!sram_wen) mem[sram_a] <= sram_d;
        sram_q <= mem[sram_a];
    end

    task automatic drive_idle();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    // Ends at a falling edge with reset released and inputs idle
    task automatic do_reset();
        @(negedge clk);
        reset = 0;
        drive_idle();
        repeat (2) @(negedge clk);
        reset = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 0;
        drive_idle();
        repeat (2) @(negedge clk);
        checks++; if (sram_wen !== 1'b1) $display("FAIL reset_wen got %b want 1", sram_wen); else passes++;
        checks++; if (sram_a !== 10'h000) $display("FAIL reset_a got %h want 000", sram_a); else passes++;
        checks++; if (sram_d !== 8'h00) $display("FAIL reset_d got %h want 00", sram_d); else passes++;
        reset = 1;
        #1;
        checks++; if ({gnt0, gnt1} !== 2'b00) $display("FAIL reset_gnt got %b want 00", {gnt0, gnt1}); else passes++;
        @(negedge clk);
        checks++; if ({rvalid0, rvalid1} !== 2'b00) $display("FAIL reset_rvalid got %b want 00", {rvalid0, rvalid1}); else passes++;
        checks++; if (sram_wen !== 1'b1) $display("FAIL idle_wen got %b want 1", sram_wen); else passes++;
    endtask

    task automatic test_write_read();
        do_reset();
        req0 = 1; we0 = 1; addr0 = 10'h005; wdata0 = 8'h03;
        #1;
        checks++; if ({gnt0, gnt1} !== 2'b10) $display("FAIL wr_gnt got %b want 10", {gnt0, gnt1}); else passes++;
        @(negedge clk);
        checks++; if ({sram_wen, sram_a, sram_d} !== {1'b0, 10'h005, 8'h03})
            $display("FAIL wr_port got %b/%h/%h want 0/005/03", sram_wen, sram_a, sram_d); else passes++;
        req0 = 0; we0 = 0;
        req1 = 1; we1 = 0; addr1 = 10'h005;
        #1;
        checks++; if ({gnt0, gnt1} !== 2'b01) $display("FAIL rd_gnt got %b want 01", {gnt0, gnt1}); else passes++;
        @(negedge clk);
        req1 = 0;
        checks++; if ({rvalid0, rvalid1} !== 2'b00) $display("FAIL wr_no_rvalid got %b want 00", {rvalid0, rvalid1}); else passes++;
        checks++; if ({sram_wen, sram_a} !== {1'b1, 10'h005}) $display("FAIL rd_port got %b/%h want 1/005", sram_wen, sram_a); else passes++;
        @(negedge clk);
        checks++; if ({rvalid0, rvalid1} !== 2'b01) $display("FAIL raw_rvalid got %b want 01", {rvalid0, rvalid1}); else passes++;
        checks++; if (rdata !== 8'h03) $display("FAIL raw_rdata got %h want 03", rdata); else passes++;
        @(negedge clk);
        checks++; if ({rvalid0, rvalid1} !== 2'b00) $display("FAIL raw_rvalid_end got %b want 00", {rvalid0, rvalid1}); else passes++;
    endtask

    task automatic test_alternate();
        logic e0 [8];
        logic e1 [8];
        logic v0, v1;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            v0 = (k >= 2) ? e0[k-2] : 1'b0;
            v1 = (k >= 2) ? e1[k-2] : 1'b0;
            checks++; if ({rvalid0, rvalid1} !== {v0, v1})
                $display("FAIL alt_rvalid[%0d] got %b want %b", k, {rvalid0, rvalid1}, {v0, v1}); else passes++;
            if (v0 || v1) begin
                checks++; if (rdata !== (v0 ? 8'h31 : 8'h61))
                    $display("FAIL alt_rdata[%0d] got %h want %h", k, rdata, v0 ? 8'h31 : 8'h61); else passes++;
            end
            if (k < 6) begin
                req0 = 1; req1 = 1; addr0 = 10'h010; addr1 = 10'h020;
`ifdef CLE_ARB_FIXED_PRIO_EN
                e0[k] = 1'b1;
`else
                e0[k] = (k % 2 == 0);
`endif
                e1[k] = ~e0[k];
                #1;
                checks++; if ({gnt0, gnt1} !== {e0[k], e1[k]})
                    $display("FAIL alt_gnt[%0d] got %b want %b", k, {gnt0, gnt1}, {e0[k], e1[k]}); else passes++;
            end else begin
                req0 = 0; req1 = 0;
                e0[k] = 1'b0; e1[k] = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lock1();
        logic [5:0] exp1;
`ifdef CLE_ARB_FIXED_PRIO_EN
        exp1 = 6'b001111;
`else
        exp1 = 6'b101111;
`endif
        do_reset();
        for (int k = 0; k < 6; k++) begin
            req0 = (k > 0); req1 = 1; lock1 = 1;
            #1;
            checks++; if ({gnt0, gnt1} !== {~exp1[k], exp1[k]})
                $display("FAIL lock1_gnt[%0d] got %b want %b", k, {gnt0, gnt1}, {~exp1[k], exp1[k]}); else passes++;
            @(negedge clk);
        end
        drive_idle();
    endtask

    task automatic test_lock0_release();
        logic [5:0] exp0;
        exp0 = 6'b101111;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            req0 = 1; req1 = 1; lock0 = 1;
            #1;
            checks++; if ({gnt0, gnt1} !== {exp0[k], ~exp0[k]})
                $display("FAIL lock0_gnt[%0d] got %b want %b", k, {gnt0, gnt1}, {exp0[k], ~exp0[k]}); else passes++;
            @(negedge clk);
        end
        drive_idle();
    endtask

    task automatic test_owner_drop();
        do_reset();
        req1 = 1; lock1 = 1;
        #1;
        checks++; if ({gnt0, gnt1} !== 2'b01) $display("FAIL drop_first got %b want 01", {gnt0, gnt1}); else passes++;
        @(negedge clk);
        req1 = 0; lock1 = 0; req0 = 1;
        #1;
        checks++; if ({gnt0, gnt1} !== 2'b10) $display("FAIL drop_handover got %b want 10", {gnt0, gnt1}); else passes++;
        @(negedge clk);
        req0 = 0; req1 = 1;
        #1;
        checks++; if ({gnt0, gnt1} !== 2'b01) $display("FAIL drop_after got %b want 01", {gnt0, gnt1}); else passes++;
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_fixed_prio();
`ifdef CLE_ARB_FIXED_PRIO_EN
        do_reset();
        for (int k = 0; k < 4; k++) begin
            req0 = 1; req1 = 1;
            #1;
            checks++; if ({gnt0, gnt1} !== 2'b10) $display("FAIL fixed_gnt[%0d] got %b want 10", k, {gnt0, gnt1}); else passes++;
            @(negedge clk);
        end
        drive_idle();
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        req1 = 1; lock1 = 1; addr1 = 10'h007;
        #1;
        checks++; if ({gnt0, gnt1} !== 2'b01) $display("FAIL mid_gnt got %b want 01", {gnt0, gnt1}); else passes++;
        @(negedge clk);
        drive_idle();
        reset = 0;
        @(negedge clk);
        checks++; if ({rvalid0, rvalid1} !== 2'b00) $display("FAIL mid_rvalid got %b want 00", {rvalid0, rvalid1}); else passes++;
        checks++; if ({sram_wen, sram_a, sram_d} !== {1'b1, 10'h000, 8'h00})
            $display("FAIL mid_port got %b/%h/%h want 1/000/00", sram_wen, sram_a, sram_d); else passes++;
        reset = 1;
        req0 = 1; req1 = 1;
        #1;
        checks++; if ({gnt0, gnt1} !== 2'b10) $display("FAIL mid_lock_clear got %b want 10", {gnt0, gnt1}); else passes++;
        @(negedge clk);
        drive_idle();
        checks++; if ({rvalid0, rvalid1} !== 2'b00) $display("FAIL mid_rvalid_late got %b want 00", {rvalid0, rvalid1}); else passes++;
        @(negedge clk);
    endtask

    initial begin
        reset = 0;
        drive_idle();
        test_reset();
        test_write_read();
        test_alternate();
        test_lock1();
        test_lock0_release();
        test_owner_drop();
        test_fixed_prio();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
